// File: rtl/powlib_pipe.sv
// powlib_pipe: D-stage valid/ready register pipeline with bubble collapse.
//
// Each stage holds a data word and a valid bit. A stage loads from its
// upstream neighbour whenever it is empty or the stage after it is moving,
// so empty slots (bubbles) are squeezed out while the output is stalled.
// The ready chain is purely combinational, which gives full throughput
// and no registered ready.
//
// Parameters:
//   W    - data width in bits (>= 1)
//   D    - number of register stages (>= 0; 0 gives a pure wire-through)
//   INIT - value loaded into every data register on reset / power-up
//   EBP  - 1: honour qrdy; 0: qrdy ignored (fixed D-cycle delay line)
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-low reset
//   d    - upstream data             vld  - upstream valid
//   rdy  - pipe accepts d this cycle (combinational)
//   q    - downstream data (last stage register)
//   qvld - q is valid                qrdy - downstream accepts q
//   occ  - number of valid stages (0..D)
module powlib_pipe #(
  parameter int             W    = 16,
  parameter int             D    = 2,
  parameter logic [W-1:0]   INIT = '0,
  parameter int             EBP  = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [W-1:0]                            d,
  input  logic                                    vld,
  output logic                                    rdy,
  output logic [W-1:0]                            q,
  output logic                                    qvld,
  input  logic                                    qrdy,
  output logic [((D == 0) ? 1 : $clog2(D + 1))-1:0] occ
);

  localparam int   OW     = (D == 0) ? 1 : $clog2(D + 1);
  localparam logic BP_OFF = (EBP == 0) ? 1'b1 : 1'b0;

  generate
    if (D == 0) begin : g_wire
      // No storage: the block degenerates to wires.
      assign q    = d;
      assign qvld = vld;
      assign rdy  = qrdy | BP_OFF;
      assign occ  = '0;

      logic unused_s;
      assign unused_s = clk ^ rst;
    end else begin : g_pipe
      logic [D:0]   en_s;
      logic [D-1:0] v_in_s;
      logic [D-1:0] v_nxt_s;
      logic [W-1:0] d_in_s [D];

      // Declaration initialisers make power-up state equal reset state.
      logic [D-1:0]  v_r    = '0;
      logic [W-1:0]  data_r [D] = '{default: INIT};
      logic [OW-1:0] occ_r  = '0;

      function automatic logic [OW-1:0] popcnt(input logic [D-1:0] v);
        logic [OW-1:0] c;
        c = '0;
        for (int k = 0; k < D; k++) begin
          c = c + OW'(v[k]);
        end
        return c;
      endfunction

      // Enable chain: a stage moves if it is empty or its successor moves.
      always_comb begin
        en_s    = '0;
        en_s[D] = qrdy | BP_OFF;
        for (int i = D - 1; i >= 0; i--) begin
          en_s[i] = ~v_r[i] | en_s[i+1];
        end
      end

      // Upstream source for every stage (stage 0 takes the input port).
      always_comb begin
        v_in_s    = '0;
        d_in_s    = '{default: '0};
        v_in_s[0] = vld;
        d_in_s[0] = d;
        for (int i = 1; i < D; i++) begin
          v_in_s[i] = v_r[i-1];
          d_in_s[i] = data_r[i-1];
        end
      end

      // Next valid vector, also used to keep occ registered.
      always_comb begin
        v_nxt_s = v_r;
        for (int i = 0; i < D; i++) begin
          if (en_s[i]) begin
            v_nxt_s[i] = v_in_s[i];
          end else begin
            v_nxt_s[i] = v_r[i];
          end
        end
      end

      // Stage registers; reset overrides any transfer in the same cycle.
      // Data loads on enable even for bubbles so the datapath needs no
      // extra gating on the valid bit.
      always_ff @(posedge clk) begin
        if (!rst) begin
          v_r   <= '0;
          occ_r <= '0;
          for (int i = 0; i < D; i++) begin
            data_r[i] <= INIT;
          end
        end else begin
          v_r   <= v_nxt_s;
          occ_r <= popcnt(v_nxt_s);
          for (int i = 0; i < D; i++) begin
            if (en_s[i]) begin
              data_r[i] <= d_in_s[i];
            end
          end
        end
      end

      assign rdy  = en_s[0];
      assign q    = data_r[D-1];
      assign qvld = v_r[D-1];
      assign occ  = occ_r;
    end
  endgenerate

endmodule

// File: tb/tb_powlib_pipe.sv
// Self-checking bench for powlib_pipe.
// u_dut : W=8, D=3, EBP=1  (main table-driven checks)
// u_dly : W=8, D=2, EBP=0  (fixed-delay sequence with qrdy held low)
// u_wir : W=8, D=0, EBP=1  (combinational pass-through, shares u_dut inputs)
module tb_powlib_pipe;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic       vld;
  logic       rdy;
  logic [7:0] q;
  logic       qvld;
  logic       qrdy;
  logic [1:0] occ;

  logic [7:0] d2;
  logic       vld2;
  logic       rdy2;
  logic [7:0] q2;
  logic       qvld2;
  logic       qrdy2;
  logic [1:0] occ2;

  logic       rdy0;
  logic [7:0] q0;
  logic       qvld0;
  logic [0:0] occ0;

  int n_cmp = 0;
  int n_bad = 0;

  powlib_pipe #(.W(8), .D(3), .INIT(8'h00), .EBP(1)) u_dut (
    .clk(clk), .rst(rst), .d(d), .vld(vld), .rdy(rdy),
    .q(q), .qvld(qvld), .qrdy(qrdy), .occ(occ)
  );

  powlib_pipe #(.W(8), .D(2), .INIT(8'h00), .EBP(0)) u_dly (
    .clk(clk), .rst(rst), .d(d2), .vld(vld2), .rdy(rdy2),
    .q(q2), .qvld(qvld2), .qrdy(qrdy2), .occ(occ2)
  );

  powlib_pipe #(.W(8), .D(0), .INIT(8'h00), .EBP(1)) u_wir (
    .clk(clk), .rst(rst), .d(d), .vld(vld), .rdy(rdy0),
    .q(q0), .qvld(qvld0), .qrdy(qrdy), .occ(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row: inputs driven for a cycle, and the outputs expected while
  // those inputs are applied (state reflects all earlier edges).
  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] d;
    logic       qrdy;
    logic       e_rdy;
    logic       e_qvld;
    logic [7:0] e_q;
    logic       chk_q;
    logic [1:0] e_occ;
  } vec_t;

  vec_t vecs[$];

  logic       v2s [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] d2s [10] = '{8'h7E, 8'h81, 8'h33, 8'hC3, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};

  task automatic add(input logic r, input logic v, input logic [7:0] dd, input logic qr,
                     input logic er, input logic eqv, input logic [7:0] eq,
                     input logic cq, input logic [1:0] eo);
    vec_t t;
    t = '{r, v, dd, qr, er, eqv, eq, cq, eo};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b0; vld = 1'b0; d = 8'h00; qrdy = 1'b1;
    vld2 = 1'b0; d2 = 8'h00; qrdy2 = 1'b0;

    //   rst  vld  d      qrdy   rdy  qvld q      chkq occ
    // reset held two cycles with a word offered
    add(1'b0, 1'b1, 8'h55, 1'b1,  1'b1, 1'b0, 8'h00, 1'b1, 2'd0);
    add(1'b0, 1'b1, 8'h55, 1'b1,  1'b1, 1'b0, 8'h00, 1'b1, 2'd0);
    add(1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0, 8'h00, 1'b1, 2'd0);
    // streaming 01..05 with qrdy high: latency 3, no gaps
    add(1'b1, 1'b1, 8'h01, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
    add(1'b1, 1'b1, 8'h02, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 2'd1);
    add(1'b1, 1'b1, 8'h03, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 2'd2);
    add(1'b1, 1'b1, 8'h04, 1'b1,  1'b1, 1'b1, 8'h01, 1'b1, 2'd3);
    add(1'b1, 1'b1, 8'h05, 1'b1,  1'b1, 1'b1, 8'h02, 1'b1, 2'd3);
    add(1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'h03, 1'b1, 2'd3);
    add(1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'h04, 1'b1, 2'd2);
    add(1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'h05, 1'b1, 2'd1);
    add(1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
    // fill under backpressure, hold A3, then out/in on the same edge
    add(1'b1, 1'b1, 8'hA0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
    add(1'b1, 1'b1, 8'hA1, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 2'd1);
    add(1'b1, 1'b1, 8'hA2, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 2'd2);
    add(1'b1, 1'b1, 8'hA3, 1'b0,  1'b0, 1'b1, 8'hA0, 1'b1, 2'd3);
    add(1'b1, 1'b1, 8'hA3, 1'b0,  1'b0, 1'b1, 8'hA0, 1'b1, 2'd3);
    add(1'b1, 1'b1, 8'hA3, 1'b1,  1'b1, 1'b1, 8'hA0, 1'b1, 2'd3);
    add(1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b1, 8'hA1, 1'b1, 2'd3);
    add(1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'hA1, 1'b1, 2'd3);
    add(1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'hA2, 1'b1, 2'd2);
    add(1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'hA3, 1'b1, 2'd1);
    add(1'b1, 1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
    // bubble collapse: 10, idle, 11 under backpressure
    add(1'b1, 1'b1, 8'h10, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
    add(1'b1, 1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 2'd1);
    add(1'b1, 1'b1, 8'h11, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 2'd1);
    add(1'b1, 1'b0, 8'h00, 1'b0,  1'b1, 1'b1, 8'h10, 1'b1, 2'd2);
    add(1'b1, 1'b0, 8'h00, 1'b0,  1'b1, 1'b1, 8'h10, 1'b1, 2'd2);
    add(1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'h10, 1'b1, 2'd2);
    add(1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'h11, 1'b1, 2'd1);
    add(1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
    // fill, then reset mid-operation: held words must vanish
    add(1'b1, 1'b1, 8'h21, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
    add(1'b1, 1'b1, 8'h22, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 2'd1);
    add(1'b1, 1'b1, 8'h23, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 2'd2);
    add(1'b0, 1'b1, 8'h24, 1'b1,  1'b1, 1'b1, 8'h21, 1'b1, 2'd3);
    add(1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0, 8'h00, 1'b1, 2'd0);
    add(1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
    add(1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst  = vecs[i].rst;
      vld  = vecs[i].vld;
      d    = vecs[i].d;
      qrdy = vecs[i].qrdy;
      #1;
      chk($sformatf("row%0d rdy", i), 32'(rdy), 32'(vecs[i].e_rdy));
      chk($sformatf("row%0d qvld", i), 32'(qvld), 32'(vecs[i].e_qvld));
      if (vecs[i].chk_q) begin
        chk($sformatf("row%0d q", i), 32'(q), 32'(vecs[i].e_q));
      end
      chk($sformatf("row%0d occ", i), 32'(occ), 32'(vecs[i].e_occ));
      // D=0 instance is a wire: outputs follow the same inputs directly
      chk($sformatf("row%0d wire q", i), 32'(q0), 32'(vecs[i].d));
      chk($sformatf("row%0d wire qvld", i), 32'(qvld0), 32'(vecs[i].vld));
      chk($sformatf("row%0d wire rdy", i), 32'(rdy0), 32'(vecs[i].qrdy));
      chk($sformatf("row%0d wire occ", i), 32'(occ0), 32'd0);
    end

    // Fixed two-cycle delay with backpressure disabled and qrdy low.
    // The delay line was idle (vld2=0, d2=0) since reset, so the first
    // two cycles show zeros.
    for (int k = 0; k < 10; k++) begin
      logic       ev;
      logic [7:0] ed;
      @(negedge clk);
      vld2  = v2s[k];
      d2    = d2s[k];
      qrdy2 = 1'b0;
      #1;
      if (k >= 2) begin
        ev = v2s[k-2];
        ed = d2s[k-2];
      end else begin
        ev = 1'b0;
        ed = 8'h00;
      end
      chk($sformatf("dly%0d rdy", k), 32'(rdy2), 32'd1);
      chk($sformatf("dly%0d qvld", k), 32'(qvld2), 32'(ev));
      chk($sformatf("dly%0d q", k), 32'(q2), 32'(ed));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
